lvds_frame_scheduler: RTL

Raster read scheduler for the LVDS test frame buffer (`ram`, XSIZE×YSIZE pixels). It walks horizontal and vertical counters over active and blanking periods. During active pixels it issues one read per clock (rd, addrX, addrY). It generates de/hsync/vsync, delayed by the RAM read latency so they align with the RAM d_out stream feeding the LVDS serializer.

---
 rtl/lvds_frame_scheduler.sv | 93 +++++++++
 1 files changed

// File: rtl/lvds_frame_scheduler.sv
// lvds_frame_scheduler: raster read scheduler for the LVDS test frame buffer with latency-aligned syncs
module lvds_frame_scheduler #(
    parameter int XSIZE    = 1280,
    parameter int YSIZE    = 800,
    parameter int HBLANK   = 160,
    parameter int VBLANK   = 23,
    parameter int HS_START = 48,
    parameter int HS_WIDTH = 32,
    parameter int VS_START = 3,
    parameter int VS_WIDTH = 6,
    parameter int RD_LAT   = 1
) (
    input  logic        clkq,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] addrX,
    output logic [31:0] addrY,
    output logic        rd,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic        busy,
    output logic [15:0] frame_cnt
);
    localparam logic [11:0] HMAX = 12'(XSIZE + HBLANK - 1);
    localparam logic [11:0] XS   = 12'(XSIZE);
    localparam logic [11:0] HS0  = 12'(XSIZE + HS_START);
    localparam logic [11:0] HS1  = 12'(XSIZE + HS_START + HS_WIDTH);
    localparam logic [10:0] VMAX = 11'(YSIZE + VBLANK - 1);
    localparam logic [10:0] YS   = 11'(YSIZE);
    localparam logic [10:0] VS0  = 11'(YSIZE + VS_START);
    localparam logic [10:0] VS1  = 11'(YSIZE + VS_START + VS_WIDTH);
    localparam logic [31:0] XINC = 32'(XSIZE);
    localparam bit LEGAL = XSIZE <= 2048 && HBLANK >= HS_START + HS_WIDTH &&
                           VBLANK >= VS_START + VS_WIDTH && RD_LAT >= 1 && RD_LAT <= 4;

    typedef enum logic {IDLE, RUN} state_t;
    state_t      state;
    logic [11:0] hcnt, nh;
    logic [10:0] vcnt, nv;
    logic [31:0] acc, nacc;
    logic        run, h_max, v_max, eof, nrun, nrd, hs_r, vs_r;
    logic [2:0]  pipe [RD_LAT];

    // Outputs are registered from next-state counters so they line up with hcnt/vcnt
    always_comb begin
        run   = state == RUN;
        h_max = hcnt == HMAX;
        v_max = vcnt == VMAX;
        eof   = run && h_max && v_max;
        nrun  = run ? !(eof && !en) : en;
        nh    = (run && !h_max) ? hcnt + 12'd1 : '0;
        nv    = !run ? '0 : !h_max ? vcnt : v_max ? '0 : vcnt + 11'd1;
        nacc  = !run ? '0 : !h_max ? acc : v_max ? '0 : acc + XINC;
        nrd   = nrun && nh < XS && nv < YS;
    end

    assign busy = state == RUN;
    assign {de, hsync, vsync} = pipe[RD_LAT-1];

    always_ff @(posedge clkq) begin
        assert (LEGAL);
        if (!rst_n) begin
            state       <= IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            acc         <= '0;
            rd          <= 1'b0;
            addrX       <= '0;
            addrY       <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            hs_r        <= 1'b0;
            vs_r        <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            state       <= nrun ? RUN : IDLE;
            hcnt        <= nh;
            vcnt        <= nv;
            acc         <= nacc;
            rd          <= nrd;
            addrX       <= nrd ? nh[10:0] : '0;
            addrY       <= nv < YS ? nacc : '0;
            frame_start <= nrd && nh == '0 && nv == '0;
            frame_cnt   <= frame_cnt + 16'(eof);
            hs_r        <= nrun && nh >= HS0 && nh < HS1;
            vs_r        <= nrun && nv >= VS0 && nv < VS1;
            pipe[0]     <= {rd, hs_r, vs_r};
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
endmodule
